// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem read per instruction and holds the result for decode.
// Every output is registered. A redirect overrides all other events and squashes any fetch in flight.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                IMM_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [IMM_W+3:0]  imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        opcode,
  output logic [IMM_W-1:0]  imm,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [ADDR_W-1:0] addr_nx, ipc_nx;
  logic [IMM_W+3:0]  ir, ir_nx;
  logic              req_nx, valid_nx;
  logic              discard, discard_nx;

  assign opcode = ir[IMM_W+3:IMM_W];
  assign imm    = ir[IMM_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      ir          <= '0;
      instr_pc    <= '0;
      discard     <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      imem_req    <= req_nx;
      imem_addr   <= addr_nx;
      instr_valid <= valid_nx;
      ir          <= ir_nx;
      instr_pc    <= ipc_nx;
      discard     <= discard_nx;
    end
  end

  // imem_req is high for the single cycle the FSM spends in S_REQ with a request
  // on the bus; every transition into S_REQ launches that request one edge early
  // so the fetch loop runs at one instruction per three cycles.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    req_nx     = 1'b0;
    addr_nx    = imem_addr;
    valid_nx   = instr_valid;
    ir_nx      = ir;
    ipc_nx     = instr_pc;
    discard_nx = discard;

    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_nx = redirect_target;
        end else if (imem_req) begin
          state_nx = S_WAIT;
        end else begin
          req_nx  = 1'b1;
          addr_nx = pc;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_nx = redirect_target;
          if (imem_rvalid) begin
            discard_nx = 1'b0;
            state_nx   = S_REQ;
            req_nx     = 1'b1;
            addr_nx    = redirect_target;
          end else begin
            discard_nx = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard) begin
            discard_nx = 1'b0;
            state_nx   = S_REQ;
            req_nx     = 1'b1;
            addr_nx    = pc;
          end else begin
            ir_nx    = imem_rdata;
            ipc_nx   = pc;
            pc_nx    = pc + PC_ONE;
            valid_nx = 1'b1;
            state_nx = S_VALID;
          end
        end
      end

      S_VALID: begin
        if (redirect_valid) begin
          valid_nx = 1'b0;
          pc_nx    = redirect_target;
          state_nx = S_REQ;
          req_nx   = 1'b1;
          addr_nx  = redirect_target;
        end else if (instr_ready) begin
          valid_nx = 1'b0;
          state_nx = S_REQ;
          req_nx   = 1'b1;
          addr_nx  = pc;
        end
      end

      default: state_nx = S_REQ;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus a RESET_PC wrap sequence.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance, RESET_PC = 0
  logic        rst_n, imem_req, imem_rvalid, instr_valid, instr_ready, redirect_valid;
  logic [7:0]  imem_addr, imm, instr_pc, redirect_target;
  logic [11:0] imem_rdata;
  logic [3:0]  opcode;

  // second instance, RESET_PC = 0xFF
  logic        rst2, req2, rv2, vld2, rdy2, redir2;
  logic [7:0]  addr2, imm2, pc2, tgt2;
  logic [11:0] rd2;
  logic [3:0]  op2;

  instr_fetch_unit #(.ADDR_W(8), .IMM_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .opcode(opcode), .imm(imm), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target));

  instr_fetch_unit #(.ADDR_W(8), .IMM_W(8), .RESET_PC(8'hFF)) dut2 (
    .clk(clk), .rst_n(rst2), .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rv2), .imem_rdata(rd2), .instr_valid(vld2),
    .instr_ready(rdy2), .opcode(op2), .imm(imm2), .instr_pc(pc2),
    .redirect_valid(redir2), .redirect_target(tgt2));

  typedef struct {
    logic       rst, rdy, redir;
    logic [7:0] tgt;
    int         lat;
    logic       req;
    logic [7:0] addr;
    logic       vld;
    logic [3:0] op;
    logic [7:0] imm, pc;
  } vec_t;

  vec_t        tv[$];
  logic [11:0] mem [256];
  int          errors = 0, checks = 0;
  int          cur_lat = 1;
  logic        pend1 = 1'b0, pend2 = 1'b0;
  int          cd1 = 0, cd2 = 0;
  logic [7:0]  pa1 = '0, pa2 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Memory responders: a request seen in cycle n answers in cycle n+lat.
  task automatic mem_step();
    imem_rvalid = 1'b0;
    if (pend1) begin
      cd1--;
      if (cd1 == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem[pa1];
        pend1       = 1'b0;
      end
    end
    if (imem_req === 1'b1) begin
      pend1 = 1'b1;
      cd1   = cur_lat;
      pa1   = imem_addr;
    end
    rv2 = 1'b0;
    if (pend2) begin
      cd2--;
      if (cd2 == 0) begin
        rv2   = 1'b1;
        rd2   = mem[pa2];
        pend2 = 1'b0;
      end
    end
    if (req2 === 1'b1) begin
      pend2 = 1'b1;
      cd2   = 1;
      pa2   = addr2;
    end
  endtask

  task automatic add(input logic rst, rdy, redir, input logic [7:0] tgt, input int lat,
                     input logic req, input logic [7:0] addr,
                     input logic vld, input logic [3:0] op, input logic [7:0] im, pc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.redir = redir; v.tgt = tgt; v.lat = lat;
    v.req = req; v.addr = addr; v.vld = vld; v.op = op; v.imm = im; v.pc = pc;
    tv.push_back(v);
  endtask

  initial begin
    logic [7:0] a;
    logic       found;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      mem[i] = {a[3:0] ^ 4'h9, a};
    end
    mem[0] = 12'h205;
    mem[1] = 12'h003;

    rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    rst2 = 1'b0; rdy2 = 1'b1; redir2 = 1'b0; tgt2 = '0; rv2 = 1'b0; rd2 = '0;

    repeat (2) begin @(negedge clk); mem_step(); end
    @(negedge clk);
    chk("reset imem_req", imem_req, 1'b0);
    chk("reset imem_addr", imem_addr, 8'h00);
    chk("reset instr_valid", instr_valid, 1'b0);
    chk("reset opcode", opcode, 4'h0);
    chk("reset imm", imm, 8'h00);
    chk("reset instr_pc", instr_pc, 8'h00);
    mem_step();

    // rst rdy rd tgt  lat  req addr  vld op imm pc
    add(0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 0  reset
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 1
    add(1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 2  first req
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 3  rvalid
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 1, 4'h2, 8'h05, 8'h00); // 4  instr 0
    add(1, 1, 0, 8'h00, 1, 1, 8'h01, 0, 4'h0, 8'h00, 8'h00); // 5
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 6
    for (int i = 0; i < 5; i++)                              // 7-11 stall
      add(1, 0, 0, 8'h00, 1, 0, 8'h00, 1, 4'h0, 8'h03, 8'h01);
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 1, 4'h0, 8'h03, 8'h01); // 12 consume
    add(1, 1, 0, 8'h00, 1, 1, 8'h02, 0, 4'h0, 8'h00, 8'h00); // 13
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 14
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 1, 4'hB, 8'h02, 8'h02); // 15
    add(1, 1, 0, 8'h00, 4, 1, 8'h03, 0, 4'h0, 8'h00, 8'h00); // 16 latency 4
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 17
    add(1, 1, 1, 8'h40, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 18 redirect in wait
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 19
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 20 stale dropped
    add(1, 1, 0, 8'h00, 1, 1, 8'h40, 0, 4'h0, 8'h00, 8'h00); // 21
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 22
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 1, 4'h9, 8'h40, 8'h40); // 23
    add(1, 1, 0, 8'h00, 2, 1, 8'h41, 0, 4'h0, 8'h00, 8'h00); // 24 latency 2
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 25
    add(1, 1, 1, 8'h10, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 26 redirect + rvalid
    add(1, 1, 0, 8'h00, 1, 1, 8'h10, 0, 4'h0, 8'h00, 8'h00); // 27
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 28
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 1, 4'h9, 8'h10, 8'h10); // 29
    add(1, 1, 0, 8'h00, 3, 1, 8'h11, 0, 4'h0, 8'h00, 8'h00); // 30 latency 3
    add(0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 31 reset in wait
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 32
    add(1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 33 stale rvalid here
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 34
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 1, 4'h2, 8'h05, 8'h00); // 35
    add(1, 1, 1, 8'h20, 1, 1, 8'h01, 0, 4'h0, 8'h00, 8'h00); // 36 redirect in req
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 37 no req issued
    add(1, 1, 0, 8'h00, 1, 1, 8'h20, 0, 4'h0, 8'h00, 8'h00); // 38
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 39
    add(1, 1, 1, 8'h30, 1, 0, 8'h00, 1, 4'h9, 8'h20, 8'h20); // 40 redirect in valid
    add(1, 1, 0, 8'h00, 1, 1, 8'h30, 0, 4'h0, 8'h00, 8'h00); // 41
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 8'h00, 8'h00); // 42
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 1, 4'h9, 8'h30, 8'h30); // 43
    add(1, 1, 0, 8'h00, 1, 1, 8'h31, 0, 4'h0, 8'h00, 8'h00); // 44

    foreach (tv[k]) begin
      @(negedge clk);
      if (k > 0) begin
        chk($sformatf("r%0d imem_req", k), imem_req, tv[k].req);
        if (tv[k].req) chk($sformatf("r%0d imem_addr", k), imem_addr, tv[k].addr);
        chk($sformatf("r%0d instr_valid", k), instr_valid, tv[k].vld);
        if (tv[k].vld) begin
          chk($sformatf("r%0d opcode", k), opcode, tv[k].op);
          chk($sformatf("r%0d imm", k), imm, tv[k].imm);
          chk($sformatf("r%0d instr_pc", k), instr_pc, tv[k].pc);
        end
      end
      rst_n           = tv[k].rst;
      instr_ready     = tv[k].rdy;
      redirect_valid  = tv[k].redir;
      redirect_target = tv[k].tgt;
      cur_lat         = tv[k].lat;
      mem_step();
    end

    // RESET_PC = 0xFF: first fetch at 0xFF, then wrap to 0x00.
    @(negedge clk); rst2 = 1'b0; mem_step();
    @(negedge clk); rst2 = 1'b1; mem_step();
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (req2) begin found = 1'b1; chk("wrap first addr", addr2, 8'hFF); end
      mem_step();
    end
    if (!found) timeout("wrap first req");
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (vld2) begin
        found = 1'b1;
        chk("wrap instr_pc", pc2, 8'hFF);
        chk("wrap opcode", op2, 4'h6);
        chk("wrap imm", imm2, 8'hFF);
      end
      mem_step();
    end
    if (!found) timeout("wrap instr_valid");
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (req2) begin found = 1'b1; chk("wrap next addr", addr2, 8'h00); end
      mem_step();
    end
    if (!found) timeout("wrap next req");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
